// File: rtl/dmem_responder_if.sv
// CPU data-port bundle between the mem stage and dmem_responder.
interface dmem_responder_if;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        addr_err;

    modport master (
        output mem_en, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata, mem_stall, addr_err
    );

    modport slave (
        input  mem_en, mem_wen, mem_addr, mem_wdata,
        output mem_rdata, mem_stall, addr_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for the CPU data port.
// Define DMEM_POSTED_WRITE_EN to retire writes on the request edge.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        Idle,
        Busy,
        Done
    } state_t;

    typedef struct packed {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    localparam int         Depth    = 1 << ADDR_W;
    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

    state_t            state;
    state_t            stateNext;
    logic [3:0]        cnt;
    req_t              req;
    logic [31:0]       rdataQ;
    logic              errQ;
    logic [31:0]       ram [Depth];

    req_t              acc;
    logic              accNow;
    logic              accWrite;
    logic              accInRange;
    logic [ADDR_W-1:0] accIdx;
    logic              postedWrite;
    logic              unusedBits;

`ifdef DMEM_POSTED_WRITE_EN
    assign postedWrite = (state == Idle) && bus.mem_en
                       && (bus.mem_wen != 4'b0000);
`else
    assign postedWrite = 1'b0;
`endif

    // A posted write takes its operands straight from the bus
    always_comb begin
        acc    = req;
        accNow = 1'b0;
        if (postedWrite) begin
            acc    = '{wen: bus.mem_wen,
                       addr: bus.mem_addr,
                       wdata: bus.mem_wdata};
            accNow = 1'b1;
        end else if (state == Busy && cnt == 4'd0) begin
            accNow = 1'b1;
        end
    end

    assign accIdx     = acc.addr[ADDR_W+1:2];
    assign accInRange = (acc.addr[31:ADDR_W+2] == '0);
    assign accWrite   = (acc.wen != 4'b0000);
    assign unusedBits = ^acc.addr[1:0];

    always_comb begin
        stateNext = state;
        unique case (1'b1)
            state == Idle: begin
                if (postedWrite)
                    stateNext = Done;
                else if (bus.mem_en)
                    stateNext = Busy;
            end
            state == Busy: begin
                if (cnt == 4'd0)
                    stateNext = Done;
            end
            state == Done: stateNext = Idle;
            default:       stateNext = Idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= Idle;
        else
            state <= stateNext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= 4'd0;
            req    <= '0;
            rdataQ <= '0;
            errQ   <= 1'b0;
        end else begin
            errQ <= 1'b0;
            if (state == Idle && bus.mem_en) begin
                req   <= '{wen: bus.mem_wen,
                           addr: bus.mem_addr,
                           wdata: bus.mem_wdata};
                cnt   <= WaitInit;
            end else if (state == Busy && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (accNow) begin
                errQ <= !accInRange;
                if (!accInRange)
                    rdataQ <= '0;
                else if (!accWrite)
                    rdataQ <= ram[accIdx];
            end
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (rst && accNow && accWrite && accInRange) begin
            for (int i = 0; i < 4; i++) begin
                if (acc.wen[i])
                    ram[accIdx][8*i +: 8] <= acc.wdata[8*i +: 8];
            end
        end
    end

    assign bus.mem_rdata = rdataQ;
    assign bus.addr_err  = errQ;
    assign bus.mem_stall = bus.mem_en && (state != Done);
endmodule
